seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit active-low 7-segment display.
- Shares one BCD-to-7-segment decoder across four digit positions and drives active-low digit enables.
- Adds tear-free frame-synchronous update via a load handshake, inter-digit blanking (anti-ghosting) and optional leading-zero blanking.
- Sits between the value producers (counters, switch logic) and the display pins.

Parameters:
- TICK_DIV, 50000, clock cycles per digit slot; legal range is at least 2.
- BLANK_CYC, 16, dead-time cycles at the start of each slot with all digits off; must be less than TICK_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- load_i  in  1  request: capture data_i for display
- data_i  in  16  four BCD nibbles; digit k = data_i[4k+3:4k]; digit 0 rightmost
- lzb_en_i  in  1  leading-zero blanking enable (level)
- seg_o  out  [0:6]  shared segment bus, active-low, bit 0 = segment a
- dig_n_o  out  4  digit enables, active-low, bit k = digit k
- pend_o  out  1  update pending, not yet committed
- upd_ack_o  out  1  one-cycle pulse: pending value committed
- frame_o  out  1  one-cycle pulse: frame boundary

Interface decision: one clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values (async, rst_n=0):
  - prescaler cnt=0, slot=0, display reg disp=0, pending reg pdat=0, pend=0.
  - seg_o=7'b1111111, dig_n_o=4'b1111, pend_o=0, upd_ack_o=0, frame_o=0.
  - Reset mid-frame aborts the scan and discards any pending value.
- Counters:
  - cnt counts 0..TICK_DIV-1 and wraps.
  - slot increments when cnt==TICK_DIV-1, wrapping 3->0.
  - Frame = 4*TICK_DIV cycles.
  - Frame end = the cycle with cnt==TICK_DIV-1 and slot==3.
- Outputs:
  - All outputs are registered. seg_o and dig_n_o at cycle t reflect cnt, slot and disp at cycle t-1.
  - seg_o and dig_n_o always change in the same cycle.
- Blanking window (cnt<BLANK_CYC): dig_n_o=4'b1111 and seg_o=7'b1111111.
- Active window:
  - dig_n_o has only bit [slot] low.
  - seg_o = decode(disp nibble[slot]) using the decode table below.
- Decode table (segments a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001101, 8=0000000, 9=0000100
  - Nibbles 10-15 give 1111111 with the digit enable still asserted.
- Leading-zero blanking (lzb_en_i=1):
  - Digit k (k=3,2,1) is suppressed when its nibble and all higher nibbles are 0.
  - A suppressed slot keeps dig_n_o=4'b1111 for the whole slot. Digit 0 is never suppressed.
  - lzb_en_i is sampled each cycle and evaluated on disp, not on pdat.
- Load handshake:
  - load_i outside frame end: pdat<=data_i, pend<=1. A repeat load while pend=1 overwrites pdat (last wins).
  - At frame end with pend=1 and no load_i: disp<=pdat, pend<=0.
  - At frame end with load_i=1: disp<=data_i directly and pend<=0; any older pdat is dropped.
  - upd_ack_o pulses in the cycle after any commit. There is no commit or pulse at frame end when there is neither pend nor load.
  - pend_o mirrors pend and is never high for a frame-end direct load.
- frame_o pulses in the cycle after every frame end, regardless of commit.
- First digit-0 slot after a commit shows the new value; a frame never mixes old and new digits.

Decomposition:
- Shared package seg_pkg:
  - SEG_BLANK=7'b1111111 and DIG_OFF=4'b1111.
  - The 16-entry segment pattern constant array.
  - N_DIG=4.
- One combinational sub-module, seg_decode (4-bit nibble in, [0:6] active-low pattern out), instanced once and shared by the slot mux.
- Prescaler, slot counter, commit logic and blanking stay in the top module.

Test Plan:
All scenarios use TICK_DIV=8, BLANK_CYC=2, giving a 32-cycle frame with frame end at cycles 31, 63, ...
1. Reset asserted at cycle 13 mid-scan -> outputs immediately 7F/F; after release, cnt and slot restart from 0; disp=0, so digit 0 shows 0000001 with dig_n_o=1110 in the active window.
2. load_i with data_i=16'h1234 at cycle 5 ->
   - pend_o=1 at cycles 6..31.
   - Commit at cycle 31; upd_ack_o=1 at cycle 32 only.
   - Slot 0 active shows 1001100 (4) with dig_n_o=1110.
   - Slot 3 shows 1001111 (1) with dig_n_o=0111.
3. data_i=16'h0070 committed, lzb_en_i=1 -> slots 3 and 2 have dig_n_o=1111 throughout; slot 1 shows 0001101; slot 0 shows 0000001. With lzb_en_i=0, slot 3 shows 0000001 and dig_n_o=0111.
4. Loads 16'h1111 at cycle 40 and 16'h2222 at cycle 50 -> single commit at cycle 63 of 2222; exactly one upd_ack_o pulse (cycle 64); 1111 never displayed.
5. load_i=16'h9999 exactly at frame end (cycle 63) while an older 16'h1111 is pending -> disp=9999 directly; pend_o low from cycle 64; one upd_ack_o at cycle 64; 1111 never displayed.
6. Nibble 4'hA in digit 2 -> during slot 2 active window dig_n_o=1011, seg_o=1111111; in the blanking window (cnt 0,1) dig_n_o=1111 for every slot.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment scan controller.
// Segment patterns are active-low, index 0 = segment a.
package seg_pkg;

  localparam int N_DIG = 4;

  localparam logic [0:6]       SEG_BLANK = 7'b1111111;
  localparam logic [N_DIG-1:0] DIG_OFF   = 4'b1111;

  // Non-BCD nibbles (10..15) decode to all segments off.
  localparam logic [0:6] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
    7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// BCD nibble to active-low 7-segment pattern; one instance shared by all digits.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [0:6] seg_o
);

  assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit scan controller: prescaler, slot counter, frame-synchronous update,
// inter-digit blanking and optional leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] data_i,
  input  logic        lzb_en_i,
  output logic [0:6]  seg_o,
  output logic [3:0]  dig_n_o,
  output logic        pend_o,
  output logic        upd_ack_o,
  output logic        frame_o
);

  localparam int            CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [15:0]   disp_q, disp_d, pdat_q, pdat_d;
  logic          pend_q, pend_d;
  logic [0:6]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;
  logic          ack_q, ack_d, frame_q, frame_d;

  logic          tick, frame_end, suppress;
  logic [3:0]    nib;
  logic [0:6]    nib_seg;

  assign tick      = (cnt_q == CNT_MAX);
  assign frame_end = tick && (slot_q == 2'd3);

  seg_decode u_dec (
    .nib_i (nib),
    .seg_o (nib_seg)
  );

  // A digit is suppressed only if it and every more significant nibble are zero.
  always_comb begin
    nib      = disp_q[3:0];
    suppress = 1'b0;
    unique case (slot_q)
      2'd3: begin nib = disp_q[15:12]; suppress = (disp_q[15:12] == '0); end
      2'd2: begin nib = disp_q[11:8];  suppress = (disp_q[15:8]  == '0); end
      2'd1: begin nib = disp_q[7:4];   suppress = (disp_q[15:4]  == '0); end
      default: begin nib = disp_q[3:0]; suppress = 1'b0; end
    endcase
    suppress = suppress & lzb_en_i;
  end

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    slot_d = tick ? slot_q + 2'd1 : slot_q;

    seg_d = SEG_BLANK;
    dig_d = DIG_OFF;
    if (!(cnt_q < BLANK_END) && !suppress) begin
      seg_d         = nib_seg;
      dig_d[slot_q] = 1'b0;
    end

    // Commit only at frame end so a frame never mixes old and new digits.
    disp_d  = disp_q;
    pdat_d  = pdat_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    frame_d = frame_end;
    if (frame_end) begin
      if (load_i) begin
        disp_d = data_i;
        pend_d = 1'b0;
        ack_d  = 1'b1;
      end else if (pend_q) begin
        disp_d = pdat_q;
        pend_d = 1'b0;
        ack_d  = 1'b1;
      end
    end else if (load_i) begin
      pdat_d = data_i;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      slot_q  <= '0;
      disp_q  <= '0;
      pdat_q  <= '0;
      pend_q  <= 1'b0;
      seg_q   <= SEG_BLANK;
      dig_q   <= DIG_OFF;
      ack_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      disp_q  <= disp_d;
      pdat_q  <= pdat_d;
      pend_q  <= pend_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      ack_q   <= ack_d;
      frame_q <= frame_d;
    end
  end

  assign seg_o     = seg_q;
  assign dig_n_o   = dig_q;
  assign pend_o    = pend_q;
  assign upd_ack_o = ack_q;
  assign frame_o   = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with an 8-cycle slot / 32-cycle frame; committed
// values flow through a scoreboard queue into a per-cycle output predictor.
module tb_seg_scan_ctrl;

  localparam int TD = 8;
  localparam int BC = 2;
  localparam logic [0:6] TBL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
    7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        lzb_en_i = 1'b0;
  logic [0:6]  seg_o;
  logic [3:0]  dig_n_o;
  logic        pend_o, upd_ack_o, frame_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] sb_q[$];

  seg_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load_i),
    .data_i    (data_i),
    .lzb_en_i  (lzb_en_i),
    .seg_o     (seg_o),
    .dig_n_o   (dig_n_o),
    .pend_o    (pend_o),
    .upd_ack_o (upd_ack_o),
    .frame_o   (frame_o)
  );

  always #5 clk = ~clk;

  // cycle 0 is the period right after reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Output predictor: expected outputs for the next cycle are built from this
  // cycle's position and the display value taken off the scoreboard.
  logic [0:6]  p_seg = 7'b1111111;
  logic [3:0]  p_dig = 4'b1111;
  logic        p_frame = 1'b0;
  logic [15:0] exp_disp = '0;
  int          m_cnt, m_slot;
  logic [3:0]  m_nib;
  logic        m_sup;

  always @(negedge clk) begin
    if (!rst_n) begin
      total++;
      if (seg_o !== 7'b1111111 || dig_n_o !== 4'b1111) begin
        bad++;
        $display("FAIL mon_reset cyc=%0d: seg=%b dig=%b required 1111111/1111", cyc, seg_o, dig_n_o);
      end
      p_seg = 7'b1111111; p_dig = 4'b1111; p_frame = 1'b0; exp_disp = '0;
      sb_q.delete();
    end else begin
      total++;
      if (seg_o !== p_seg || dig_n_o !== p_dig || frame_o !== p_frame) begin
        bad++;
        $display("FAIL mon_scan cyc=%0d: seg=%b dig=%b frame=%b required %b %b %b",
                 cyc, seg_o, dig_n_o, frame_o, p_seg, p_dig, p_frame);
      end
      if (upd_ack_o === 1'b1) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL mon_ack cyc=%0d: upd_ack_o=1 required 0 (nothing to commit)", cyc);
        end else begin
          exp_disp = sb_q.pop_front();
        end
      end
      m_cnt  = cyc % TD;
      m_slot = (cyc / TD) % 4;
      p_seg  = 7'b1111111;
      p_dig  = 4'b1111;
      if (m_cnt >= BC) begin
        m_nib = exp_disp[m_slot*4 +: 4];
        m_sup = lzb_en_i && (m_slot != 0) && ((exp_disp >> (m_slot*4)) == 16'h0);
        if (!m_sup) begin
          p_seg = TBL[m_nib];
          p_dig[m_slot] = 1'b0;
        end
      end
      p_frame = (cyc % (4*TD) == 4*TD - 1);
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load_i = 1'b0; data_i = '0; lzb_en_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_load(input int at, input logic [15:0] d);
    goto(at);
    load_i = 1'b1; data_i = d;
    goto(at + 1);
    load_i = 1'b0;
  endtask

  task automatic check_sb_empty(input string name);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s_sb: %0d commits outstanding, required 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    pulse_load(3, 16'h4321);
    total++;
    if (pend_o !== 1'b1) begin bad++; $display("FAIL rst_pend_pre: pend_o=%b required 1", pend_o); end
    goto(13);
    rst_n = 1'b0;
    #1;
    total++;
    if (seg_o !== 7'b1111111 || dig_n_o !== 4'b1111 || pend_o !== 1'b0 || upd_ack_o !== 1'b0 || frame_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: seg=%b dig=%b pend=%b ack=%b frame=%b required 1111111 1111 0 0 0",
               seg_o, dig_n_o, pend_o, upd_ack_o, frame_o);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    goto(3);
    total++;
    if (seg_o !== 7'b0000001 || dig_n_o !== 4'b1110) begin
      bad++; $display("FAIL rst_digit0: seg=%b dig=%b required 0000001 1110", seg_o, dig_n_o);
    end
    goto(32);
    total++;
    if (frame_o !== 1'b1 || upd_ack_o !== 1'b0 || pend_o !== 1'b0) begin
      bad++; $display("FAIL rst_frame: frame=%b ack=%b pend=%b required 1 0 0", frame_o, upd_ack_o, pend_o);
    end
    check_sb_empty("rst");
  endtask

  task automatic test_load();
    do_reset();
    sb_q.push_back(16'h1234);
    pulse_load(5, 16'h1234);
    for (int c = 6; c <= 31; c++) begin
      goto(c);
      total++;
      if (pend_o !== 1'b1 || upd_ack_o !== 1'b0) begin
        bad++; $display("FAIL load_pend cyc=%0d: pend=%b ack=%b required 1 0", c, pend_o, upd_ack_o);
      end
    end
    goto(32);
    total++;
    if (upd_ack_o !== 1'b1 || pend_o !== 1'b0 || frame_o !== 1'b1) begin
      bad++; $display("FAIL load_commit: ack=%b pend=%b frame=%b required 1 0 1", upd_ack_o, pend_o, frame_o);
    end
    goto(33);
    total++;
    if (upd_ack_o !== 1'b0) begin bad++; $display("FAIL load_ack_once: ack=%b required 0", upd_ack_o); end
    goto(35);
    total++;
    if (seg_o !== 7'b1001100 || dig_n_o !== 4'b1110) begin
      bad++; $display("FAIL load_slot0: seg=%b dig=%b required 1001100 1110", seg_o, dig_n_o);
    end
    goto(59);
    total++;
    if (seg_o !== 7'b1001111 || dig_n_o !== 4'b0111) begin
      bad++; $display("FAIL load_slot3: seg=%b dig=%b required 1001111 0111", seg_o, dig_n_o);
    end
    check_sb_empty("load");
  endtask

  task automatic test_lzb();
    do_reset();
    lzb_en_i = 1'b1;
    sb_q.push_back(16'h0070);
    pulse_load(1, 16'h0070);
    goto(35);
    total++;
    if (seg_o !== 7'b0000001 || dig_n_o !== 4'b1110) begin
      bad++; $display("FAIL lzb_d0: seg=%b dig=%b required 0000001 1110", seg_o, dig_n_o);
    end
    goto(43);
    total++;
    if (seg_o !== 7'b0001101 || dig_n_o !== 4'b1101) begin
      bad++; $display("FAIL lzb_d1: seg=%b dig=%b required 0001101 1101", seg_o, dig_n_o);
    end
    for (int c = 49; c <= 64; c++) begin
      goto(c);
      total++;
      if (dig_n_o !== 4'b1111) begin
        bad++; $display("FAIL lzb_sup cyc=%0d: dig=%b required 1111", c, dig_n_o);
      end
    end
    lzb_en_i = 1'b0;
    goto(83);
    total++;
    if (seg_o !== 7'b0000001 || dig_n_o !== 4'b1011) begin
      bad++; $display("FAIL lzb_off_d2: seg=%b dig=%b required 0000001 1011", seg_o, dig_n_o);
    end
    goto(91);
    total++;
    if (seg_o !== 7'b0000001 || dig_n_o !== 4'b0111) begin
      bad++; $display("FAIL lzb_off_d3: seg=%b dig=%b required 0000001 0111", seg_o, dig_n_o);
    end
    check_sb_empty("lzb");
  endtask

  task automatic test_last_wins();
    do_reset();
    pulse_load(40, 16'h1111);
    total++;
    if (pend_o !== 1'b1) begin bad++; $display("FAIL lw_pend1: pend_o=%b required 1", pend_o); end
    sb_q.push_back(16'h2222);
    pulse_load(50, 16'h2222);
    for (int c = 51; c <= 63; c++) begin
      goto(c);
      total++;
      if (pend_o !== 1'b1 || upd_ack_o !== 1'b0) begin
        bad++; $display("FAIL lw_pend cyc=%0d: pend=%b ack=%b required 1 0", c, pend_o, upd_ack_o);
      end
    end
    goto(64);
    total++;
    if (upd_ack_o !== 1'b1 || pend_o !== 1'b0) begin
      bad++; $display("FAIL lw_commit: ack=%b pend=%b required 1 0", upd_ack_o, pend_o);
    end
    goto(65);
    total++;
    if (upd_ack_o !== 1'b0) begin bad++; $display("FAIL lw_ack_once: ack=%b required 0", upd_ack_o); end
    goto(67);
    total++;
    if (seg_o !== 7'b0010010 || dig_n_o !== 4'b1110) begin
      bad++; $display("FAIL lw_slot0: seg=%b dig=%b required 0010010 1110", seg_o, dig_n_o);
    end
    goto(100);
    check_sb_empty("lw");
  endtask

  task automatic test_frame_end_load();
    do_reset();
    pulse_load(40, 16'h1111);
    goto(63);
    total++;
    if (pend_o !== 1'b1) begin bad++; $display("FAIL fe_pend_pre: pend_o=%b required 1", pend_o); end
    sb_q.push_back(16'h9999);
    pulse_load(63, 16'h9999);
    total++;
    if (pend_o !== 1'b0 || upd_ack_o !== 1'b1 || frame_o !== 1'b1) begin
      bad++; $display("FAIL fe_commit: pend=%b ack=%b frame=%b required 0 1 1", pend_o, upd_ack_o, frame_o);
    end
    goto(65);
    total++;
    if (pend_o !== 1'b0 || upd_ack_o !== 1'b0) begin
      bad++; $display("FAIL fe_after: pend=%b ack=%b required 0 0", pend_o, upd_ack_o);
    end
    goto(67);
    total++;
    if (seg_o !== 7'b0000100 || dig_n_o !== 4'b1110) begin
      bad++; $display("FAIL fe_slot0: seg=%b dig=%b required 0000100 1110", seg_o, dig_n_o);
    end
    goto(100);
    check_sb_empty("fe");
  endtask

  task automatic test_nibble_a();
    logic [0:6] es [4];
    logic [3:0] ed [4];
    es = '{7'b0000000, 7'b0000110, 7'b1111111, 7'b0100100};
    ed = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    do_reset();
    sb_q.push_back(16'h5A38);
    pulse_load(1, 16'h5A38);
    for (int s = 0; s < 4; s++) begin
      for (int k = 1; k <= 2; k++) begin
        goto(32 + 8*s + k);
        total++;
        if (seg_o !== 7'b1111111 || dig_n_o !== 4'b1111) begin
          bad++; $display("FAIL nA_blank slot=%0d cnt=%0d: seg=%b dig=%b required 1111111 1111", s, k-1, seg_o, dig_n_o);
        end
      end
      goto(35 + 8*s);
      total++;
      if (seg_o !== es[s] || dig_n_o !== ed[s]) begin
        bad++; $display("FAIL nA_active slot=%0d: seg=%b dig=%b required %b %b", s, seg_o, dig_n_o, es[s], ed[s]);
      end
    end
    check_sb_empty("nA");
  endtask

  initial begin
    test_reset();
    test_load();
    test_lzb();
    test_last_wins();
    test_frame_end_load();
    test_nibble_a();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
